pkt_stream_sink: RTL and testbench

- Terminating receiver for the 134-bit UM packet stream (pktout side of um).
- Checks the framing tag in bits[133:132]: 01 = head, 11 = body, 10 = tail.
- Buffers each packet in a store-and-forward FIFO. A packet becomes readable only after a good tail; bad, discarded or overflowed packets are rolled back.
- Drives the upstream ready flag and keeps good/drop/error statistics for host readout.

---
 rtl/pkt_stream_sink.sv | 234 +++++++++++++++++++++++
 tb/tb_pkt_stream_sink.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_stream_sink.sv
// Store-and-forward sink for the 134-bit UM packet stream with framing checks and statistics.
// Define PKT_SINK_STAT_SAT_EN to make the statistics counters saturate instead of wrap.
module pkt_stream_sink #(
  parameter int ADDR_W   = 8,
  parameter int READY_TH = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_data_wr,
  input  logic [133:0]     in_data,
  input  logic             in_data_valid_wr,
  input  logic             in_data_valid,
  output logic             in_ready,
  input  logic             out_rd,
  output logic [133:0]     out_data,
  output logic             out_data_vld,
  output logic             out_empty,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int               DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0]  DEPTH_P = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]  PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]  TH_P    = (ADDR_W + 1)'(READY_TH);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W - 1){1'b0}}, 1'b1};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BODY = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_BODY = 2'b11;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
`ifdef PKT_SINK_STAT_SAT_EN
    if (v == {CNT_W{1'b1}}) begin
      cnt_inc = v;
    end else begin
      cnt_inc = v + CNT_ONE;
    end
`else
    cnt_inc = v + CNT_ONE;
`endif
  endfunction

  logic [1:0]       state_q, state_d;
  logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]  commit_ptr_q, commit_ptr_d;
  logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] good_cnt_q, drop_cnt_q, err_cnt_q;
  logic             in_ready_q, out_data_vld_q, out_empty_q;
  logic [133:0]     out_data_q;
  logic [133:0]     mem_q [DEPTH];

  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic              good_inc_s, drop_inc_s, err_inc_s;
  logic [1:0]        tag_s;
  logic              full_wr_s, full_commit_s, rd_en_s;
  logic [ADDR_W:0]   free_s;

  assign tag_s         = in_data[133:132];
  assign full_wr_s     = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
  assign full_commit_s = (commit_ptr_q - rd_ptr_q) == DEPTH_P;
  assign free_s        = DEPTH_P - (wr_ptr_q - rd_ptr_q);
  assign rd_en_s       = out_rd && (rd_ptr_q != commit_ptr_q);

  // Read pointer advances only on an accepted read of committed data.
  always_comb begin
    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Framing FSM: writes, commits, rollbacks and statistic events for each beat.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    mem_we_s     = 1'b0;
    mem_waddr_s  = wr_ptr_q[ADDR_W-1:0];
    good_inc_s   = 1'b0;
    drop_inc_s   = 1'b0;
    err_inc_s    = 1'b0;
    if (in_data_wr) begin
      case (state_q)
        ST_IDLE: begin
          if (tag_s != TAG_HEAD) begin
            err_inc_s = 1'b1;
          end else if (full_wr_s) begin
            state_d = ST_DROP;
          end else begin
            mem_we_s = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            state_d  = ST_BODY;
          end
        end
        ST_BODY: begin
          case (tag_s)
            TAG_BODY: begin
              if (full_wr_s) begin
                wr_ptr_d = commit_ptr_q;
                state_d  = ST_DROP;
              end else begin
                mem_we_s = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
              end
            end
            TAG_TAIL: begin
              state_d = ST_IDLE;
              if (in_data_valid_wr && in_data_valid && !full_wr_s) begin
                mem_we_s     = 1'b1;
                wr_ptr_d     = wr_ptr_q + PTR_ONE;
                commit_ptr_d = wr_ptr_q + PTR_ONE;
                good_inc_s   = 1'b1;
              end else if (in_data_valid_wr) begin
                // Discard status or no room for the tail: the whole packet drops.
                wr_ptr_d   = commit_ptr_q;
                drop_inc_s = 1'b1;
              end else begin
                wr_ptr_d  = commit_ptr_q;
                err_inc_s = 1'b1;
              end
            end
            TAG_HEAD: begin
              err_inc_s = 1'b1;
              if (full_commit_s) begin
                wr_ptr_d = commit_ptr_q;
                state_d  = ST_DROP;
              end else begin
                mem_we_s    = 1'b1;
                mem_waddr_s = commit_ptr_q[ADDR_W-1:0];
                wr_ptr_d    = commit_ptr_q + PTR_ONE;
              end
            end
            default: begin
              err_inc_s = 1'b1;
              wr_ptr_d  = commit_ptr_q;
              state_d   = ST_IDLE;
            end
          endcase
        end
        ST_DROP: begin
          case (tag_s)
            TAG_TAIL: begin
              drop_inc_s = 1'b1;
              state_d    = ST_IDLE;
            end
            TAG_HEAD: begin
              err_inc_s  = 1'b1;
              drop_inc_s = 1'b1;
              if (full_commit_s) begin
                state_d = ST_DROP;
              end else begin
                mem_we_s    = 1'b1;
                mem_waddr_s = commit_ptr_q[ADDR_W-1:0];
                wr_ptr_d    = commit_ptr_q + PTR_ONE;
                state_d     = ST_BODY;
              end
            end
            default: begin
              state_d = ST_DROP;
            end
          endcase
        end
        default: begin
          wr_ptr_d = commit_ptr_q;
          state_d  = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Packet buffer; contents are don't-care until committed, so it carries no reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= in_data;
    end
  end

  // Pointers, FSM state, statistics and registered read-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      wr_ptr_q       <= '0;
      commit_ptr_q   <= '0;
      rd_ptr_q       <= '0;
      good_cnt_q     <= '0;
      drop_cnt_q     <= '0;
      err_cnt_q      <= '0;
      in_ready_q     <= 1'b1;
      out_data_q     <= '0;
      out_data_vld_q <= 1'b0;
      out_empty_q    <= 1'b1;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      commit_ptr_q   <= commit_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      if (good_inc_s) begin
        good_cnt_q <= cnt_inc(good_cnt_q);
      end
      if (drop_inc_s) begin
        drop_cnt_q <= cnt_inc(drop_cnt_q);
      end
      if (err_inc_s) begin
        err_cnt_q <= cnt_inc(err_cnt_q);
      end
      in_ready_q     <= (free_s >= TH_P);
      out_data_vld_q <= rd_en_s;
      if (rd_en_s) begin
        out_data_q <= mem_q[rd_ptr_q[ADDR_W-1:0]];
      end
      out_empty_q    <= (rd_ptr_d == commit_ptr_d);
    end
  end

  assign in_ready     = in_ready_q;
  assign out_data     = out_data_q;
  assign out_data_vld = out_data_vld_q;
  assign out_empty    = out_empty_q;
  assign good_cnt     = good_cnt_q;
  assign drop_cnt     = drop_cnt_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_pkt_stream_sink.sv
// Bench for pkt_stream_sink: queue-based packet model checked every cycle, plus directed scenarios.
module tb_pkt_stream_sink;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int TH    = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int M_IDLE = 0, M_PKT = 1, M_DROP = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_data_wr = 1'b0;
  logic [133:0]  in_data = '0;
  logic          in_data_valid_wr = 1'b0;
  logic          in_data_valid = 1'b0;
  logic          out_rd = 1'b0;
  logic          in_ready, out_data_vld, out_empty;
  logic [133:0]  out_data;
  logic [CW-1:0] good_cnt, drop_cnt, err_cnt;

  pkt_stream_sink #(.ADDR_W(AW), .READY_TH(TH), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data_wr(in_data_wr), .in_data(in_data),
    .in_data_valid_wr(in_data_valid_wr), .in_data_valid(in_data_valid),
    .in_ready(in_ready), .out_rd(out_rd), .out_data(out_data),
    .out_data_vld(out_data_vld), .out_empty(out_empty),
    .good_cnt(good_cnt), .drop_cnt(drop_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [133:0] act, input logic [133:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  function automatic int bump(input int c);
`ifdef PKT_SINK_STAT_SAT_EN
    return (c == CMAX) ? c : c + 1;
`else
    return (c + 1) % (CMAX + 1);
`endif
  endfunction

  function automatic logic [133:0] bt(input logic [1:0] tg, input int n);
    return {tg, 132'(n)};
  endfunction

  // Reference model: committed beats, the open packet, and the receiver mode.
  logic [133:0] cq[$];
  logic [133:0] oq[$];
  int           mode = M_IDLE;
  int           m_good = 0, m_drop = 0, m_err = 0;
  logic         want_ready = 1'b1, want_vld = 1'b0, want_empty = 1'b1;
  logic [133:0] want_data = '0;

  always @(posedge clk) begin : model_b
    int csz, osz;
    logic [1:0] tg;
    logic nr;
    if (!rst_n) begin
      cq.delete(); oq.delete();
      mode = M_IDLE; m_good = 0; m_drop = 0; m_err = 0;
      want_ready = 1'b1; want_vld = 1'b0; want_data = '0; want_empty = 1'b1;
    end else begin
      csz = cq.size();
      osz = oq.size();
      nr  = (DEPTH - (csz + osz)) >= TH;
      if (out_rd && csz > 0) begin
        want_data = cq.pop_front();
        want_vld  = 1'b1;
      end else begin
        want_vld = 1'b0;
      end
      if (in_data_wr) begin
        tg = in_data[133:132];
        case (mode)
          M_IDLE: begin
            if (tg != 2'b01) m_err = bump(m_err);
            else if (csz == DEPTH) mode = M_DROP;
            else begin oq.push_back(in_data); mode = M_PKT; end
          end
          M_PKT: begin
            case (tg)
              2'b11: begin
                if (csz + osz == DEPTH) begin oq.delete(); mode = M_DROP; end
                else oq.push_back(in_data);
              end
              2'b10: begin
                if (in_data_valid_wr && in_data_valid && (csz + osz < DEPTH)) begin
                  oq.push_back(in_data);
                  foreach (oq[i]) cq.push_back(oq[i]);
                  m_good = bump(m_good);
                end else if (in_data_valid_wr) begin
                  m_drop = bump(m_drop);
                end else begin
                  m_err = bump(m_err);
                end
                oq.delete();
                mode = M_IDLE;
              end
              2'b01: begin
                m_err = bump(m_err);
                oq.delete();
                if (csz == DEPTH) mode = M_DROP;
                else oq.push_back(in_data);
              end
              default: begin
                m_err = bump(m_err);
                oq.delete();
                mode = M_IDLE;
              end
            endcase
          end
          default: begin
            if (tg == 2'b10) begin
              m_drop = bump(m_drop);
              mode = M_IDLE;
            end else if (tg == 2'b01) begin
              m_err  = bump(m_err);
              m_drop = bump(m_drop);
              if (csz < DEPTH) begin oq.push_back(in_data); mode = M_PKT; end
            end
          end
        endcase
      end
      want_ready = nr;
      want_empty = (cq.size() == 0);
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(posedge clk) begin
    #2;
    chk("in_ready", 134'(in_ready), 134'(want_ready));
    chk("out_data_vld", 134'(out_data_vld), 134'(want_vld));
    chk("out_data", out_data, want_data);
    chk("out_empty", 134'(out_empty), 134'(want_empty));
    chk("good_cnt", 134'(good_cnt), 134'(m_good));
    chk("drop_cnt", 134'(drop_cnt), 134'(m_drop));
    chk("err_cnt", 134'(err_cnt), 134'(m_err));
  end

  task automatic tick(input logic wr, input logic [133:0] d, input logic vw,
                      input logic vv, input logic rd);
    @(negedge clk);
    in_data_wr = wr; in_data = d; in_data_valid_wr = vw; in_data_valid = vv; out_rd = rd;
    @(posedge clk);
    #3;
  endtask

  task automatic send(input logic [1:0] tg, input int n, input logic vw, input logic vv);
    tick(1'b1, bt(tg, n), vw, vv, 1'b0);
  endtask

  task automatic idle();
    tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd_chk(input string nm, input logic [133:0] want);
    tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk({nm, "_vld"}, 134'(out_data_vld), 134'(1));
    chk(nm, out_data, want);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_data_wr = 1'b0; in_data = '0; in_data_valid_wr = 1'b0; in_data_valid = 1'b0; out_rd = 1'b0;
    @(posedge clk);
    #3;
    chk("rst_in_ready", 134'(in_ready), 134'(1));
    chk("rst_out_empty", 134'(out_empty), 134'(1));
    chk("rst_out_data", out_data, 134'(0));
    chk("rst_vld", 134'(out_data_vld), 134'(0));
    chk("rst_cnts", 134'({good_cnt, drop_cnt, err_cnt}), 134'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #3;
  endtask

  initial begin
    logic saw_low;
    int r;
    logic [1:0] tg;
    logic [133:0] d;

    // Good 6-beat packet with an idle gap, then read back in order.
    do_reset();
    send(2'b01, 0, 1'b0, 1'b0);
    idle();
    for (int i = 1; i <= 4; i++) send(2'b11, i, 1'b0, 1'b0);
    chk("t1_empty_before_tail", 134'(out_empty), 134'(1));
    send(2'b10, 5, 1'b1, 1'b1);
    chk("t1_empty_after_tail", 134'(out_empty), 134'(0));
    chk("t1_good", 134'(good_cnt), 134'(1));
    chk("t1_err", 134'(err_cnt), 134'(0));
    rd_chk("t1_rd0", bt(2'b01, 0));
    for (int i = 1; i <= 4; i++) rd_chk("t1_rd_body", bt(2'b11, i));
    rd_chk("t1_rd5", bt(2'b10, 5));
    chk("t1_empty_end", 134'(out_empty), 134'(1));
    tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("t1_rd_empty_vld", 134'(out_data_vld), 134'(0));

    // Same packet discarded by status.
    do_reset();
    send(2'b01, 0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) send(2'b11, i, 1'b0, 1'b0);
    send(2'b10, 5, 1'b1, 1'b0);
    chk("t2_drop", 134'(drop_cnt), 134'(1));
    chk("t2_good", 134'(good_cnt), 134'(0));
    chk("t2_empty", 134'(out_empty), 134'(1));

    // Stray body in IDLE, then a 2-beat packet.
    do_reset();
    send(2'b11, 9, 1'b0, 1'b0);
    send(2'b01, 1, 1'b0, 1'b0);
    send(2'b10, 2, 1'b1, 1'b1);
    chk("t3_err", 134'(err_cnt), 134'(1));
    chk("t3_good", 134'(good_cnt), 134'(1));
    rd_chk("t3_rd0", bt(2'b01, 1));
    rd_chk("t3_rd1", bt(2'b10, 2));

    // Head inside an open packet restarts it.
    do_reset();
    send(2'b01, 0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) send(2'b11, i, 1'b0, 1'b0);
    send(2'b01, 10, 1'b0, 1'b0);
    send(2'b11, 11, 1'b0, 1'b0);
    send(2'b10, 12, 1'b1, 1'b1);
    chk("t4_err", 134'(err_cnt), 134'(1));
    chk("t4_good", 134'(good_cnt), 134'(1));
    rd_chk("t4_rd0", bt(2'b01, 10));
    rd_chk("t4_rd1", bt(2'b11, 11));
    rd_chk("t4_rd2", bt(2'b10, 12));
    chk("t4_empty", 134'(out_empty), 134'(1));

    // 20-beat packet overflows the 16-beat buffer and drops.
    do_reset();
    saw_low = 1'b0;
    for (int i = 0; i < 20; i++) begin
      send((i == 0) ? 2'b01 : ((i == 19) ? 2'b10 : 2'b11), i, 1'b1, 1'b1);
      if (!in_ready) saw_low = 1'b1;
      if (i == 12) chk("t5_ready_beat13", 134'(in_ready), 134'(1));
      if (i == 13) chk("t5_ready_beat14", 134'(in_ready), 134'(0));
    end
    chk("t5_saw_ready_low", 134'(saw_low), 134'(1));
    chk("t5_drop", 134'(drop_cnt), 134'(1));
    chk("t5_empty", 134'(out_empty), 134'(1));
    send(2'b01, 30, 1'b0, 1'b0);
    send(2'b10, 31, 1'b1, 1'b1);
    chk("t5_good", 134'(good_cnt), 134'(1));
    rd_chk("t5_rd0", bt(2'b01, 30));
    rd_chk("t5_rd1", bt(2'b10, 31));

    // Reset mid-packet with committed data buffered.
    do_reset();
    send(2'b01, 1, 1'b0, 1'b0);
    send(2'b10, 2, 1'b1, 1'b1);
    send(2'b01, 3, 1'b0, 1'b0);
    send(2'b10, 4, 1'b1, 1'b1);
    send(2'b01, 5, 1'b0, 1'b0);
    send(2'b11, 6, 1'b0, 1'b0);
    chk("t6_good_before", 134'(good_cnt), 134'(2));
    chk("t6_empty_before", 134'(out_empty), 134'(0));
    do_reset();
    send(2'b01, 7, 1'b0, 1'b0);
    send(2'b10, 8, 1'b1, 1'b1);
    chk("t6_good_after", 134'(good_cnt), 134'(1));
    rd_chk("t6_rd0", bt(2'b01, 7));
    rd_chk("t6_rd1", bt(2'b10, 8));

    // 20 stray beats: saturate at 15 or wrap to 4.
    do_reset();
    for (int i = 0; i < 20; i++) send(2'b11, i, 1'b0, 1'b0);
`ifdef PKT_SINK_STAT_SAT_EN
    chk("t7_err_sat", 134'(err_cnt), 134'(15));
`else
    chk("t7_err_wrap", 134'(err_cnt), 134'(4));
`endif

    // Randomized traffic: slow reads first (overflow pressure), then fast reads.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) do_reset();
      r = $urandom_range(99);
      tg = (r < 15) ? 2'b01 : ((r < 80) ? 2'b11 : ((r < 97) ? 2'b10 : 2'b00));
      d = {tg, $urandom(), $urandom(), $urandom(), $urandom(), 4'($urandom())};
      tick(($urandom_range(99) < 60), d, ($urandom_range(9) != 0), ($urandom_range(4) != 0),
           ($urandom_range(99) < ((c < 1500) ? 20 : 70)));
    end
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
